// File: rtl/mmult_pkg.sv
// Shared types and helpers for the N x N matrix multiplier.
package mmult_pkg;

  // Controller states; values are fixed so waveforms read the same across builds.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Result width wide enough that a length-n dot product never overflows,
  // signed or unsigned.
  function automatic int unsigned default_ow(input int unsigned n, input int unsigned dw);
    return 2 * dw + $clog2(n);
  endfunction

  // Row-major flat index of element (row, col) in an n x n matrix.
  function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col,
                                           input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/mmult_dot.sv
// Combinational length-N dot product, operands zero- or sign-extended to OW bits.
module mmult_dot
  import mmult_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = default_ow(N, DW)
) (
  input  logic                   is_signed,
  input  logic [N-1:0][DW-1:0]   a_row,
  input  logic [N-1:0][DW-1:0]   b_col,
  output logic [OW-1:0]          dot
);

  logic [N-1:0][OW-1:0] a_ext;
  logic [N-1:0][OW-1:0] b_ext;

  // Extend each operand to the result width; OW is assumed wider than DW.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    for (int k = 0; k < int'(N); k++) begin
      a_ext[k] = {{(OW - DW){is_signed & a_row[k][DW-1]}}, a_row[k]};
      b_ext[k] = {{(OW - DW){is_signed & b_col[k][DW-1]}}, b_col[k]};
    end
  end

  // Multiply-accumulate in OW bits; two's complement wrap handles both modes.
  always_comb begin
    logic [OW-1:0] prod;
    dot  = '0;
    prod = '0;
    for (int k = 0; k < int'(N); k++) begin
      prod = a_ext[k] * b_ext[k];
      dot  = dot + prod;
    end
  end

endmodule

// File: rtl/mmult_nxn.sv
// N x N matrix multiplier: captures A and B on start, produces one row of C per cycle.
module mmult_nxn
  import mmult_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = default_ow(N, DW)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                is_signed,
  input  logic [0:N*N*DW-1]   A_mat,
  input  logic [0:N*N*DW-1]   B_mat,
  output logic                busy,
  output logic                valid,
  output logic [0:N*N*OW-1]   C_mat
);

  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

  state_e                       state_q;
  logic [RW-1:0]                row_q;
  logic                         is_signed_q;
  logic [N-1:0][N-1:0][DW-1:0]  a_q;
  logic [N-1:0][N-1:0][DW-1:0]  b_q;
  logic [N-1:0][N-1:0][OW-1:0]  c_q;

  logic [N-1:0][DW-1:0]         a_row;
  logic [N-1:0][N-1:0][DW-1:0]  b_cols;  // b_cols[j][k] = B[k][j]
  logic [N-1:0][OW-1:0]         dot_res;

  // Select the current row of A and transpose B into per-column vectors.
  always_comb begin
    a_row  = a_q[row_q];
    b_cols = '0;
    for (int j = 0; j < int'(N); j++) begin
      for (int k = 0; k < int'(N); k++) begin
        b_cols[j][k] = b_q[k][j];
      end
    end
  end

  // One dot-product unit per output column.
  for (genvar j = 0; j < int'(N); j++) begin : g_col
    mmult_dot #(
      .N  (N),
      .DW (DW),
      .OW (OW)
    ) u_dot (
      .is_signed (is_signed_q),
      .a_row     (a_row),
      .b_col     (b_cols[j]),
      .dot       (dot_res[j])
    );
  end

  // Flatten the result register onto the row-major output bus.
  always_comb begin
    C_mat = '0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        C_mat[elem_idx(i, j, N)*OW +: OW] = c_q[i][j];
      end
    end
  end

  // Controller FSM: accept in Idle/Done, write one row of C per Calc cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      is_signed_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            for (int i = 0; i < int'(N); i++) begin
              for (int j = 0; j < int'(N); j++) begin
                a_q[i][j] <= A_mat[elem_idx(i, j, N)*DW +: DW];
                b_q[i][j] <= B_mat[elem_idx(i, j, N)*DW +: DW];
              end
            end
            is_signed_q <= is_signed;
            c_q         <= '0;
            row_q       <= '0;
            valid       <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StCalc;
          end
        end
        StCalc: begin
          c_q[row_q] <= dot_res;
          if (row_q == RW'(N - 1)) begin
            row_q   <= '0;
            busy    <= 1'b0;
            valid   <= 1'b1;
            state_q <= StDone;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/mmult_nxn.md
# mmult_nxn

Parametrised N×N matrix multiplier, successor to the fixed 3×3 unsigned mmult. It captures two N×N matrices on a start pulse and computes one row of C = A×B per cycle. Operands are treated as unsigned or two's-complement, selected at run time. It presents the full result with a level valid flag, and sits beside the lab datapath as a multi-cycle arithmetic engine driven by a controller FSM or testbench.

## Interface
- N, 3, matrix dimension, legal 2..8
- DW, 8, operand element width in bits
- OW, 2*DW+$clog2(N), result element width; the default is overflow-free in both modes
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- is_signed  in  1  operand mode, sampled with an accepted start
- A_mat  in  N*N*DW  declared [0:N*N*DW-1], row-major; element k=i*N+j at [k*DW +: DW]
- B_mat  in  N*N*DW  same layout as A_mat
- busy  out  1  high while computing
- valid  out  1  high while C_mat holds a complete result
- C_mat  out  N*N*OW  declared [0:N*N*OW-1]; element k at [k*OW +: OW]

## Operation
- States: IDLE, CALC, DONE.
- Reset (asynchronous, any state):
  - state=IDLE, row=0
  - busy=0, valid=0, C_mat=0
  - captured operands cleared
- Accept: start=1 in IDLE or DONE.
  - Captures A_mat, B_mat, is_signed.
  - C_mat cleared, row=0, valid=0, busy=1, next state CALC.
- CALC, each cycle:
  - C[row][j] = Σ_k A[row][k]·B[k][j] for all j, written to C_mat.
  - row increments.
  - After row N-1 is written: state=DONE, busy=0, valid=1.
- DONE: C_mat and valid hold until the next accept or reset.
- start during CALC is ignored; there is no queueing.
- A_mat, B_mat and is_signed changes after capture have no effect on the current computation.
- Arithmetic:
  - Unsigned mode zero-extends operands; signed mode sign-extends them.
  - Products and sums are computed in OW bits, two's complement.
  - With the default OW no overflow is possible. If OW is overridden smaller, results wrap modulo 2^OW.

## Timing
- Start accepted at edge t:
  - busy=1 and C_mat=0 after edge t.
  - Row r is visible after edge t+1+r.
  - valid=1 and busy=0 after edge t+N.
- Latency is N cycles, start to valid.
- Throughput is one matrix per N+1 cycles when start is held high continuously. A start in the DONE cycle is accepted, and valid drops at the following edge.
- start=1 together with reset_n=0: reset wins.

## Structure
- Package mmult_pkg holds:
  - state encoding localparams
  - the default-OW constant function
  - an element-index helper function
- Sub-module mmult_dot: combinational length-N dot product with an is_signed input, producing OW bits. It is instantiated N times, once per output column, and fed the captured row of A and column j of B.
- The top level holds the FSM, row counter, operand registers and C register.

## Test plan
- Base case, defaults, unsigned:
  - Stimulus: A=72'h0E5E03_391D02_003108, B=72'h0A0907_1D0502_012809.
  - Required: C=[2869 716 313; 1413 738 475; 1429 565 170]; valid rises 3 cycles after start.
- Zero operand: same A with B=0 → all C elements 0, valid=1. The previous result must be cleared at accept, not retained.
- Mode select:
  - A all 8'hFF, B all 8'h01, is_signed=1 → every element 18'h3FFFD (-3).
  - Same operands with is_signed=0 → every element 765.
  - A all 8'h80, B all 8'h80, signed → every element 49152.
- Handshake:
  - start pulsed again during CALC → ignored, result unchanged.
  - start held high from DONE → new accept, valid low one cycle, next result after 3 more cycles.
- Reset mid-operation: reset_n low in the second CALC cycle → busy=0, valid=0, C_mat=0 immediately. A subsequent start produces the correct base-case result.
- Parametric: N=4, DW=4, A=identity, B elements 0..15 → C equals B, OW=10, latency 4 cycles.
